// File: rtl/bias_relu_accum_pkg.sv
// Shared layer definitions for the convolution output stage: data width,
// accumulator sizing, activation clamp and the output-stage FSM encoding.
package bias_relu_accum_pkg;

  localparam int DW = 18;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic int acc_w(input int n_pass);
    return DW + $clog2(n_pass) + 1;
  endfunction

  // Callers sign-extend their accumulator into 64 bits so one clamp serves any ACC_W.
  function automatic logic [DW-1:0] relu_sat(input logic signed [63:0] x);
    localparam logic signed [63:0] SAT_MAX = 64'((64'sd1 <<< (DW - 1)) - 64'sd1);
    if (x < 64'sd0) begin
      return '0;
    end else if (x > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else begin
      return x[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/bias_relu_lane.sv
// One output channel: partial-sum accumulator, final bias add and the
// registered ReLU/saturated activation.
module bias_relu_lane
  import bias_relu_accum_pkg::*;
#(
  parameter int ACC_W = acc_w(9)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          acc_en,
  input  logic          fin,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] bias,
  output logic [DW-1:0] out_data
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;

  always_comb begin
    in_ext   = {{(ACC_W - DW){in_data[DW-1]}}, in_data};
    bias_ext = {{(ACC_W - DW){bias[DW-1]}}, bias};
    sum      = acc + in_ext + bias_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      out_data <= '0;
    end else if (fin) begin
      acc      <= '0;
      out_data <= relu_sat(64'(sum));
    end else if (acc_en) begin
      acc <= acc + in_ext;
    end
  end

endmodule

// File: rtl/bias_relu_accum.sv
// Convolution output stage: accumulates N_PASS partial-sum beats per pixel,
// adds bias, applies ReLU/saturation and holds the vector until accepted.
module bias_relu_accum
  import bias_relu_accum_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int N_PASS       = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [N_adder_tree*DW-1:0] in_data,
  input  logic [N_adder_tree*DW-1:0] bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_adder_tree*DW-1:0] out_data,
  output logic                       err_len
);

  localparam int ACC_W = acc_w(N_PASS);
  localparam int PCW   = $clog2(N_PASS + 1);
  localparam logic [PCW-1:0] PASS_MAX  = PCW'(N_PASS);
  localparam logic [PCW-1:0] PASS_LAST = PCW'(N_PASS - 1);

  state_e         state;
  logic [PCW-1:0] pass_cnt;
  logic           accept;
  logic           acc_en;
  logic           fin;

  // Handshake outputs depend on state alone, so out_ready never reaches in_ready combinationally.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign acc_en    = accept & ~in_last;
  assign fin       = accept & in_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACCUM;
      pass_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (fin) begin
            pass_cnt <= '0;
            if (pass_cnt != PASS_LAST) err_len <= 1'b1;
            state <= HOLD;
          end else if (acc_en) begin
            // Overrun: keep accumulating but pin the count and flag the pixel.
            if (pass_cnt >= PASS_LAST) begin
              pass_cnt <= PASS_MAX;
              err_len  <= 1'b1;
            end else begin
              pass_cnt <= pass_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
    bias_relu_lane #(
      .ACC_W(ACC_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .acc_en  (acc_en),
      .fin     (fin),
      .in_data (in_data[DW*k +: DW]),
      .bias    (bias[DW*k +: DW]),
      .out_data(out_data[DW*k +: DW])
    );
  end

endmodule

// File: doc/bias_relu_accum.md
# bias_relu_accum

Output stage of a convolution layer. Accumulates N_PASS partial-sum beats per output pixel from the per-channel adder trees, adds the per-channel constant bias vector from that layer's bias bank, applies ReLU and saturates to the 18-bit fixed-point activation format. It sits between the adder-tree lanes and the next layer's input buffer. It uses valid/ready handshakes on both sides.

## Interface
- N_adder_tree, 16, number of parallel output channels (lanes)
- DW, 18, lane width for partial sums, bias and output (signed two's complement, same Q-format throughout)
- N_PASS, 9, partial-sum beats per output pixel (≥1)
- ACC_W, DW+$clog2(N_PASS)+1, internal accumulator width per lane
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  partial-sum beat present
- in_ready  out  1  block accepts a beat this cycle
- in_last  in  1  marks final beat of the current pixel, qualified by in_valid
- in_data  in  N_adder_tree*DW  lane k at [DW*(k+1)-1 : DW*k]
- bias  in  N_adder_tree*DW  constant bias vector, same lane packing, sampled only on the last beat
- out_valid  out  1  activation vector present
- out_ready  in  1  downstream accepts
- out_data  out  N_adder_tree*DW  ReLU'd, saturated activations, same lane packing
- err_len  out  1  sticky: a pixel ended with a beat count other than N_PASS

## Operation
- FSM states: ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - in_ready=1.
  - On an accepted beat (in_valid & in_ready) with in_last=0: acc[k] += sext(in_data[k]) and pass_cnt++.
  - On an accepted beat with in_last=1:
    - sum[k] = acc[k] + sext(in_data[k]) + sext(bias[k]).
    - out_data[k] = relu_sat(sum[k]).
    - acc and pass_cnt clear to 0.
    - err_len sets if pass_cnt != N_PASS-1.
    - Next state is HOLD.
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_data holds stable until out_valid & out_ready, then the FSM returns to ACCUM.
- relu_sat on ACC_W-bit signed x:
  - x<0 gives 0.
  - x>2^(DW-1)-1 gives 2^(DW-1)-1 (0x1FFFF for DW=18).
  - Otherwise x[DW-1:0].
- Overflow guard on pass_cnt: if pass_cnt would reach N_PASS with in_last=0, the beat still accumulates, pass_cnt saturates at N_PASS, and err_len sets. The pixel completes only on in_last.
- err_len clears only on reset.
- Reset values: out_valid=0, out_data=0, err_len=0, acc=0, pass_cnt=0, state=ACCUM. in_ready=1 in the first cycle after reset deasserts.
- Reset asserted mid-pixel or in HOLD discards all state. Any pending output is lost.
- in_data and bias are ignored while in_ready=0.

## Timing
- out_valid rises in the cycle after the beat with in_last is accepted (1-cycle latency).
- in_ready is a function of state only, with no combinational path from out_ready.
- If out_ready=1 while out_valid=1, the vector is consumed and in_ready=1 on the next cycle.
- Minimum pixel period is N_PASS+1 cycles.
- Backpressure: out_valid, once high, stays high with out_data constant until accepted.
- N_PASS=1: every beat must carry in_last. The result is in_data+bias.

## Structure
- Shared layer package holds:
  - DW
  - the ACC_W function
  - relu_sat as a function
  - the FSM state enum {ACCUM, HOLD}
- One sub-module, bias_relu_lane: one lane's accumulator register, adder, and relu_sat. It is instantiated N_adder_tree times in a generate loop.
- The top level holds the FSM, pass_cnt and err_len.

## Test plan
- Nominal, N_PASS=9, lane 0: in_data=0x00010 on all 9 beats, bias=0x00578. Expect out_data lane 0 = 0x00608 one cycle after the last beat and err_len=0.
- Negative clamp: beats sum to −0x00100 and bias = 18'b111110100001010100 (negative). Expect that lane = 0.
- Positive saturation: all beats = 0x1FFFF, bias=0x01000. Expect 0x1FFFF on every lane.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Check out_data is stable, in_ready=0, and a driven in_valid is not consumed. After release, in_ready=1 on the next cycle.
- Length error: in_last asserted on beat 5 of 9. Expect an output to be produced with err_len=1 sticky. The following correct pixel yields the correct value.
- Reset mid-pixel: pull rst_n low after beat 4 for 1 cycle, then send a full 9-beat pixel. Expect the result to reflect only the new beats and all outputs to be at reset values during reset.
